// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: opcodes, funct3 codes and the ALU operation set.
package rv32i_pkg;

    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] MISC_MEM = 7'b0001111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    // funct7[5] means SUB only for register-register ops; for shifts it picks SRA in both forms
    function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic funct7b5,
                                           input logic is_reg_op);
        alu_op_e op;
        case (funct3)
            F3_ADD_SUB: op = (is_reg_op && funct7b5) ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SR:      op = funct7b5 ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_if.sv
// Instruction fetch link: word address out from the core, instruction word back.
interface rv32i_if;
    logic [29:0] addr;
    logic [31:0] inst;

    modport master (output addr, input inst);
    modport slave  (input addr, output inst);
endinterface

// File: rtl/rv32i_inst_mem.sv
// Combinational instruction ROM; contents are loaded externally and never reset.
module inst_mem #(
    parameter int IMEM_WORDS = 4096
) (
    rv32i_if.slave fetch
);
    localparam int AW = $clog2(IMEM_WORDS);

    logic [31:0] mem [0:IMEM_WORDS-1];

    // Word index wraps modulo the ROM depth so any PC fetches something defined
    assign fetch.inst = mem[AW'(fetch.addr % 30'(IMEM_WORDS))];
endmodule

// File: rtl/rv32i_cpu_top.sv
// Single-cycle RV32I integer core (ALU, upper immediates, jumps, branches; no data memory).
module rv32i_cpu_top
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 4096
) (
    input logic clk,
    input logic rst_n
);
    logic [31:0] pc_current_s1;
    logic [31:0] inst_s;
    logic [31:0] rf_r [0:31];

    logic [6:0]  opcode_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [2:0]  funct3_s;
    logic        funct7b5_s;
    logic [31:0] rs1_val_s, rs2_val_s;
    logic [31:0] imm_i_s, imm_b_s, imm_u_s, imm_j_s;
    logic [31:0] alu_b_s, alu_y_s, pc_plus4_s, pc_next_s, wb_data_s;
    logic        wb_en_s, br_taken_s;
    alu_op_e     alu_op_s;

    rv32i_if fetch_if ();

    inst_mem #(.IMEM_WORDS(IMEM_WORDS)) u_inst_mem_s1 (.fetch(fetch_if.slave));

    assign fetch_if.addr = pc_current_s1[31:2];
    assign inst_s        = fetch_if.inst;

    assign opcode_s   = inst_s[6:0];
    assign rd_s       = inst_s[11:7];
    assign funct3_s   = inst_s[14:12];
    assign rs1_s      = inst_s[19:15];
    assign rs2_s      = inst_s[24:20];
    assign funct7b5_s = inst_s[30];

    assign imm_i_s = {{20{inst_s[31]}}, inst_s[31:20]};
    assign imm_b_s = {{19{inst_s[31]}}, inst_s[31], inst_s[7], inst_s[30:25], inst_s[11:8], 1'b0};
    assign imm_u_s = {inst_s[31:12], 12'h000};
    assign imm_j_s = {{11{inst_s[31]}}, inst_s[31], inst_s[19:12], inst_s[20], inst_s[30:21], 1'b0};

    assign rs1_val_s  = (rs1_s == 5'd0) ? 32'd0 : rf_r[rs1_s];
    assign rs2_val_s  = (rs2_s == 5'd0) ? 32'd0 : rf_r[rs2_s];
    assign pc_plus4_s = pc_current_s1 + 32'd4;

    // ALU for OP and OP-IMM; second operand is rs2 or the I immediate
    always_comb begin
        alu_b_s  = (opcode_s == OP) ? rs2_val_s : imm_i_s;
        alu_op_s = alu_decode(funct3_s, funct7b5_s, (opcode_s == OP));
        case (alu_op_s)
            ALU_ADD:  alu_y_s = rs1_val_s + alu_b_s;
            ALU_SUB:  alu_y_s = rs1_val_s - alu_b_s;
            ALU_SLL:  alu_y_s = rs1_val_s << alu_b_s[4:0];
            ALU_SLT:  alu_y_s = {31'd0, ($signed(rs1_val_s) < $signed(alu_b_s))};
            ALU_SLTU: alu_y_s = {31'd0, (rs1_val_s < alu_b_s)};
            ALU_XOR:  alu_y_s = rs1_val_s ^ alu_b_s;
            ALU_SRL:  alu_y_s = rs1_val_s >> alu_b_s[4:0];
            ALU_SRA:  alu_y_s = $unsigned($signed(rs1_val_s) >>> alu_b_s[4:0]);
            ALU_OR:   alu_y_s = rs1_val_s | alu_b_s;
            ALU_AND:  alu_y_s = rs1_val_s & alu_b_s;
            default:  alu_y_s = 32'd0;
        endcase
    end

    // Branch condition; the two undefined funct3 codes never branch
    always_comb begin
        case (funct3_s)
            F3_BEQ:  br_taken_s = (rs1_val_s == rs2_val_s);
            F3_BNE:  br_taken_s = (rs1_val_s != rs2_val_s);
            F3_BLT:  br_taken_s = ($signed(rs1_val_s) < $signed(rs2_val_s));
            F3_BGE:  br_taken_s = ($signed(rs1_val_s) >= $signed(rs2_val_s));
            F3_BLTU: br_taken_s = (rs1_val_s < rs2_val_s);
            F3_BGEU: br_taken_s = (rs1_val_s >= rs2_val_s);
            default: br_taken_s = 1'b0;
        endcase
    end

    // Next-PC selection and writeback source; unlisted opcodes just advance the PC
    always_comb begin
        pc_next_s = pc_plus4_s;
        wb_en_s   = 1'b0;
        wb_data_s = 32'd0;
        case (opcode_s)
            OP, OP_IMM: begin
                wb_en_s   = 1'b1;
                wb_data_s = alu_y_s;
            end
            LUI: begin
                wb_en_s   = 1'b1;
                wb_data_s = imm_u_s;
            end
            AUIPC: begin
                wb_en_s   = 1'b1;
                wb_data_s = pc_current_s1 + imm_u_s;
            end
            JAL: begin
                wb_en_s   = 1'b1;
                wb_data_s = pc_plus4_s;
                pc_next_s = pc_current_s1 + imm_j_s;
            end
            JALR: begin
                wb_en_s   = 1'b1;
                wb_data_s = pc_plus4_s;
                pc_next_s = (rs1_val_s + imm_i_s) & 32'hFFFF_FFFE;
            end
            BRANCH: begin
                if (br_taken_s) begin
                    pc_next_s = pc_current_s1 + imm_b_s;
                end else begin
                    pc_next_s = pc_plus4_s;
                end
            end
            LOAD, STORE, MISC_MEM, SYSTEM: begin
                wb_en_s = 1'b0;
            end
            default: begin
                wb_en_s = 1'b0;
            end
        endcase
    end

    // PC and register file update; reset overrides the cycle's writeback
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc_current_s1 <= RESET_PC;
            for (int i = 0; i < 32; i++) begin
                rf_r[i] <= 32'd0;
            end
        end else begin
            pc_current_s1 <= pc_next_s;
            if (wb_en_s && (rd_s != 5'd0)) begin
                rf_r[rd_s] <= wb_data_s;
            end
        end
    end
endmodule

// File: tb/tb_rv32i_cpu_top.sv
// Self-checking bench for rv32i_cpu_top: directed programs plus random programs run against an ISS.
module tb_rv32i_cpu_top;
    localparam int W = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [31:0] m_mem [W];
    logic [31:0] m_reg [32];
    logic [31:0] m_pc;

    rv32i_cpu_top #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(W)) dut (.clk(clk), .rst_n(rst_n));

    rv32i_if mon_if ();
    assign mon_if.addr = dut.pc_current_s1[31:2];
    assign mon_if.inst = dut.inst_s;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dreg(input int i);
        return dut.rf_r[i];
    endfunction

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] u_t(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    // ---------------- reference ISS ----------------
    task automatic model_step();
        logic [31:0] in_w, a, b, sx, imm_i, imm_b, imm_u, imm_j, res, nxt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        wr, tk;
        in_w  = m_mem[m_pc[13:2]];
        op    = in_w[6:0];
        rd    = in_w[11:7];
        f3    = in_w[14:12];
        a     = m_reg[in_w[19:15]];
        b     = m_reg[in_w[24:20]];
        sx    = in_w[31] ? 32'hFFFF_FFFF : 32'h0000_0000;
        imm_i = $unsigned($signed(in_w) >>> 20);
        imm_u = in_w & 32'hFFFF_F000;
        imm_b = (sx << 12) | ({31'd0, in_w[7]} << 11) | ({26'd0, in_w[30:25]} << 5) | ({28'd0, in_w[11:8]} << 1);
        imm_j = (sx << 20) | (in_w & 32'h000F_F000) | ({31'd0, in_w[20]} << 11) | ({22'd0, in_w[30:21]} << 1);
        nxt   = m_pc + 32'd4;
        res   = 32'd0;
        wr    = 1'b0;
        tk    = 1'b0;
        if (op == 7'h33 || op == 7'h13) begin
            wr = 1'b1;
            if (op == 7'h13) b = imm_i;
            case (f3)
                3'd0:    res = (op == 7'h33 && in_w[30]) ? a - b : a + b;
                3'd1:    res = a << b[4:0];
                3'd2:    res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3:    res = (a < b) ? 32'd1 : 32'd0;
                3'd4:    res = a ^ b;
                3'd5:    res = in_w[30] ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
                3'd6:    res = a | b;
                default: res = a & b;
            endcase
        end else if (op == 7'h37) begin
            wr = 1'b1; res = imm_u;
        end else if (op == 7'h17) begin
            wr = 1'b1; res = m_pc + imm_u;
        end else if (op == 7'h6f) begin
            wr = 1'b1; res = m_pc + 32'd4; nxt = m_pc + imm_j;
        end else if (op == 7'h67) begin
            wr = 1'b1; res = m_pc + 32'd4; nxt = (a + imm_i) & 32'hFFFF_FFFE;
        end else if (op == 7'h63) begin
            case (f3)
                3'd0:    tk = (a == b);
                3'd1:    tk = (a != b);
                3'd4:    tk = ($signed(a) < $signed(b));
                3'd5:    tk = ($signed(a) >= $signed(b));
                3'd6:    tk = (a < b);
                3'd7:    tk = (a >= b);
                default: tk = 1'b0;
            endcase
            if (tk) nxt = m_pc + imm_b;
        end
        if (wr && rd != 5'd0) m_reg[rd] = res;
        m_pc = nxt;
    endtask

    // ---------------- helpers ----------------
    task automatic put(input int idx, input logic [31:0] w);
        dut.u_inst_mem_s1.mem[idx] = w;
        m_mem[idx] = w;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < W; i++) put(i, 32'h0000_0013);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        chk("reset_pc", dut.pc_current_s1, 32'd0);
    endtask

    task automatic adv(input int n);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(negedge clk);
            chk("pc", dut.pc_current_s1, m_pc);
            chk("fetch", mon_if.inst, m_mem[m_pc[13:2]]);
        end
    endtask

    task automatic chk_regs();
        for (int i = 1; i < 32; i++) chk($sformatf("x%0d", i), dreg(i), m_reg[i]);
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] r, t;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [6:0]  f7, op;
        logic [12:0] bo;
        logic [20:0] jo;
        r   = $urandom;
        t   = $urandom;
        rd  = r[4:0];
        rs1 = r[9:5];
        rs2 = r[14:10];
        f3  = r[17:15];
        imm = t[11:0];
        case ($urandom_range(0, 10))
            0, 1: begin
                f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[20]) ? 7'h20 : 7'h00;
                return r_t(f7, rs2, rs1, f3, rd);
            end
            2, 3: begin
                if (f3 == 3'd1) imm = {7'h00, imm[4:0]};
                else if (f3 == 3'd5) imm = {(r[20] ? 7'h20 : 7'h00), imm[4:0]};
                return i_t(imm, rs1, f3, rd, 7'h13);
            end
            4: return u_t(t[31:12], rd, 7'h37);
            5: return u_t(t[31:12], rd, 7'h17);
            6: begin
                bo = 13'(($urandom_range(0, 40) - 20) * 4);
                return b_t(bo, rs2, rs1, f3);
            end
            7: begin
                jo = 21'(($urandom_range(0, 64) - 32) * 4);
                return j_t(jo, rd);
            end
            8: return i_t(imm, rs1, 3'd0, rd, 7'h67);
            9: begin
                case (r[22:21])
                    2'd0:    op = 7'h03;
                    2'd1:    op = 7'h23;
                    2'd2:    op = 7'h0f;
                    default: op = 7'h73;
                endcase
                return {t[31:7], op};
            end
            default: return t;
        endcase
    endfunction

    initial begin
        // Reset with NOPs: PC sequence 0, 4, 8, 12
        fill_nop();
        do_reset();
        adv(1); chk("nop_pc4", dut.pc_current_s1, 32'd4);
        adv(1); chk("nop_pc8", dut.pc_current_s1, 32'd8);
        adv(1); chk("nop_pc12", dut.pc_current_s1, 32'd12);

        // Arithmetic, shifts, compare and x0 write
        fill_nop();
        put(0, i_t(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13));
        put(1, i_t(12'h404, 5'd1, 3'd5, 5'd2, 7'h13));
        put(2, i_t(12'h01C, 5'd1, 3'd5, 5'd3, 7'h13));
        put(3, r_t(7'h00, 5'd1, 5'd0, 3'd3, 5'd4));
        put(4, i_t(12'h007, 5'd0, 3'd0, 5'd8, 7'h13));
        put(5, i_t(12'h005, 5'd0, 3'd0, 5'd0, 7'h13));
        put(6, r_t(7'h00, 5'd0, 5'd0, 3'd0, 5'd8));
        do_reset();
        adv(7);
        chk("srai", dreg(2), 32'hFFFF_FFFF);
        chk("srli", dreg(3), 32'h0000_000F);
        chk("sltu", dreg(4), 32'h0000_0001);
        chk("x0_reads_zero", dreg(8), 32'h0000_0000);
        chk_regs();

        // Taken branch at 0x28C
        fill_nop();
        put(0, i_t(12'h001, 5'd0, 3'd0, 5'd1, 7'h13));
        put(1, j_t(21'h000288, 5'd0));
        put(32'h28C >> 2, b_t(13'h0018, 5'd0, 5'd1, 3'd1));
        do_reset();
        adv(2); chk("br_at", dut.pc_current_s1, 32'h0000_028C);
        adv(1); chk("br_taken", dut.pc_current_s1, 32'h0000_02A4);

        // Not-taken branch at 0x28C (x1 = 0)
        fill_nop();
        put(0, j_t(21'h00028C, 5'd0));
        put(32'h28C >> 2, b_t(13'h0018, 5'd0, 5'd1, 3'd1));
        do_reset();
        adv(1); chk("nbr_at", dut.pc_current_s1, 32'h0000_028C);
        adv(1); chk("br_not_taken", dut.pc_current_s1, 32'h0000_0290);

        // JAL at 0x10, then JALR to an odd-offset target with rd == rs1
        fill_nop();
        put(4, j_t(21'h000008, 5'd1));
        put(6, i_t(12'h100, 5'd0, 3'd0, 5'd1, 7'h13));
        put(7, i_t(12'h003, 5'd1, 3'd0, 5'd1, 7'h67));
        do_reset();
        adv(5);
        chk("jal_pc", dut.pc_current_s1, 32'h0000_0018);
        chk("jal_link", dreg(1), 32'h0000_0014);
        adv(2);
        chk("jalr_pc", dut.pc_current_s1, 32'h0000_0102);
        chk("jalr_link", dreg(1), 32'h0000_0020);
        adv(1);
        chk("pc_low_bits_ignored", dut.pc_current_s1, 32'h0000_0106);

        // LUI and AUIPC at 0x40
        fill_nop();
        put(0, u_t(20'h80000, 5'd5, 7'h37));
        put(16, u_t(20'h00001, 5'd6, 7'h17));
        do_reset();
        adv(17);
        chk("lui", dreg(5), 32'h8000_0000);
        chk("auipc", dreg(6), 32'h0000_1040);

        // Fetch index wraps at 16 KiB
        fill_nop();
        put(0, j_t(21'h004000, 5'd0));
        do_reset();
        adv(1);
        chk("wrap_pc", dut.pc_current_s1, 32'h0000_4000);
        chk("wrap_inst", mon_if.inst, j_t(21'h004000, 5'd0));

        // Reset mid-program suppresses that cycle's writeback
        fill_nop();
        put(0, i_t(12'h009, 5'd0, 3'd0, 5'd9, 7'h13));
        put(1, i_t(12'h00A, 5'd0, 3'd0, 5'd10, 7'h13));
        do_reset();
        adv(1);
        chk("pre_rst_x9", dreg(9), 32'd9);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_pc", dut.pc_current_s1, 32'd0);
        chk("mid_rst_x10", dreg(10), 32'd0);
        chk("mid_rst_x9", dreg(9), 32'd0);
        rst_n = 1'b0;
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        adv(2);
        chk_regs();

        // Random programs co-simulated against the ISS
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < W; i++) put(i, gen_inst());
            do_reset();
            for (int c = 0; c < 300; c++) begin
                adv(1);
                if (c % 25 == 24) chk_regs();
            end
            chk_regs();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
